// File: rtl/rx_bf_pkg.sv
// Shared defaults, FSM state type and sample/delay types for the RX delay-and-sum beamformer.
package rx_bf_pkg;

  localparam int unsigned RX_BF_NUM_CH = 4;
  localparam int unsigned RX_BF_DATA_W = 16;
  localparam int unsigned RX_BF_DEPTH  = 32;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } bf_state_t;

  typedef logic signed [RX_BF_DATA_W-1:0] sample_t;
  typedef logic [$clog2(RX_BF_DEPTH):0]   delay_t;

endpackage

// File: rtl/rx_delay_line.sv
// One channel's circular sample buffer: write at the shared pointer, registered read at pointer minus delay.
module rx_delay_line
  import rx_bf_pkg::*;
#(
  parameter int unsigned DATA_W = RX_BF_DATA_W,
  parameter int unsigned DEPTH  = RX_BF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  logic [DATA_W-1:0]        din,
  input  logic [$clog2(DEPTH)-1:0] delay,
  output logic [DATA_W-1:0]        dout
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_addr;

  // Storage carries no reset; only samples written after reset are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Address is captured with the sample so d=0 reads the value written on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      dout    <= '0;
    end else begin
      if (wr_en) rd_addr <= wr_ptr - delay;
      dout <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/rx_beamformer_param.sv
// Parameterised RX delay-and-sum beamformer with shadow/active delay banks and a FILL/RUN warm-up FSM.
// Define RX_BF_APOD_EN to add per-channel Q0.8 apodization weights.
module rx_beamformer_param
  import rx_bf_pkg::*;
#(
  parameter int unsigned NUM_CH = RX_BF_NUM_CH,
  parameter int unsigned DATA_W = RX_BF_DATA_W,
  parameter int unsigned DEPTH  = RX_BF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [NUM_CH*DATA_W-1:0]   adc_in,
  input  logic                       cfg_wr,
  input  logic [$clog2(NUM_CH)-1:0]  cfg_ch,
  input  logic [$clog2(DEPTH):0]     cfg_delay,
  input  logic [7:0]                 cfg_weight,
  input  logic                       cfg_commit,
  output logic                       cfg_err,
  output logic                       out_valid,
  output logic signed [DATA_W-1:0]   aggregated_waveform
);

  localparam int unsigned CW = $clog2(NUM_CH);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = AW + 1;
`ifdef RX_BF_APOD_EN
  localparam int unsigned PW    = DATA_W + 10;
  localparam int unsigned SHIFT = 8 + CW;
`else
  localparam int unsigned PW    = DATA_W;
  localparam int unsigned SHIFT = CW;
`endif
  localparam int unsigned SW = PW + CW;

  bf_state_t state, state_nxt;

  logic [AW-1:0] wptr;
  logic [AW-1:0] fill_cnt;
  logic [DW-1:0] shadow [NUM_CH];
  logic [DW-1:0] active [NUM_CH];
  logic [DW-1:0] shadow_nxt [NUM_CH];
  logic [DW-1:0] eff [NUM_CH];
  logic [DW-1:0] eff_max;
  logic          pending;
  logic          v1, v2;
  logic          cfg_ok_c, commit_now_c, raise_c, produce_c;

  logic signed [DATA_W-1:0] tap [NUM_CH];
  logic signed [PW-1:0]     term_c;
  logic signed [SW-1:0]     sum_c;

  // Effective delays for this edge: a commit lands with the sample, including a same-cycle write.
  always_comb begin
    cfg_ok_c     = cfg_wr && (cfg_delay <= DW'(DEPTH - 1));
    commit_now_c = in_valid && (pending || cfg_commit);
    eff_max      = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      shadow_nxt[ch] = (cfg_ok_c && (cfg_ch == CW'(ch))) ? cfg_delay : shadow[ch];
      eff[ch]        = commit_now_c ? shadow_nxt[ch] : active[ch];
      if (eff[ch] > eff_max) eff_max = eff[ch];
    end
    raise_c = eff_max > DW'(fill_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (commit_now_c && raise_c) state_nxt = FILL;
      FILL:    if (!raise_c) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // RUN already guarantees enough history unless this sample's commit raises the max delay.
  always_comb begin
    produce_c = 1'b0;
    case (state)
      RUN:     produce_c = in_valid && !(commit_now_c && raise_c);
      FILL:    produce_c = in_valid && !raise_c;
      default: produce_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      fill_cnt <= '0;
      pending  <= 1'b0;
      cfg_err  <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        shadow[ch] <= '0;
        active[ch] <= '0;
      end
    end else begin
      if (in_valid) begin
        wptr <= wptr + AW'(1);
        if (fill_cnt != AW'(DEPTH - 1)) fill_cnt <= fill_cnt + AW'(1);
      end
      pending <= (pending || cfg_commit) && !in_valid;
      cfg_err <= cfg_wr && !cfg_ok_c;
      shadow  <= shadow_nxt;
      if (commit_now_c) active <= shadow_nxt;
      v1 <= produce_c;
      v2 <= v1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rx_delay_line #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_delay_line (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (in_valid),
      .wr_ptr (wptr),
      .din    (adc_in[g*DATA_W +: DATA_W]),
      .delay  (eff[g][AW-1:0]),
      .dout   (tap[g])
    );
  end

`ifdef RX_BF_APOD_EN
  logic [7:0]        shadow_w [NUM_CH];
  logic [7:0]        active_w [NUM_CH];
  logic [7:0]        shadow_w_nxt [NUM_CH];
  logic [7:0]        eff_w [NUM_CH];
  logic [7:0]        w1 [NUM_CH];
  logic [7:0]        w2 [NUM_CH];
  logic signed [9:0] wt_c;

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      shadow_w_nxt[ch] = (cfg_ok_c && (cfg_ch == CW'(ch))) ? cfg_weight : shadow_w[ch];
      eff_w[ch]        = commit_now_c ? shadow_w_nxt[ch] : active_w[ch];
    end
  end

  // Weights travel alongside the read so each tap meets the weight in force when it was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        shadow_w[ch] <= '0;
        active_w[ch] <= '0;
        w1[ch]       <= '0;
        w2[ch]       <= '0;
      end
    end else begin
      shadow_w <= shadow_w_nxt;
      if (commit_now_c) active_w <= shadow_w_nxt;
      if (in_valid) w1 <= eff_w;
      w2 <= w1;
    end
  end
`else
  logic unused_weight;
  assign unused_weight = ^cfg_weight;
`endif

  // Full-width sum of taps; arithmetic shift gives the floored mean.
  always_comb begin
    sum_c  = '0;
    term_c = '0;
`ifdef RX_BF_APOD_EN
    wt_c   = '0;
`endif
    for (int ch = 0; ch < NUM_CH; ch++) begin
`ifdef RX_BF_APOD_EN
      wt_c   = (w2[ch] == 8'd0) ? 10'sd256 : signed'({2'b00, w2[ch]});
      term_c = PW'(tap[ch]) * PW'(wt_c);
`else
      term_c = PW'(tap[ch]);
`endif
      sum_c = sum_c + SW'(term_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid           <= 1'b0;
      aggregated_waveform <= '0;
    end else begin
      out_valid <= v2;
      if (v2) aggregated_waveform <= DATA_W'(sum_c >>> SHIFT);
    end
  end

endmodule

// File: tb/tb_rx_beamformer_param.sv
// Directed self-checking bench for rx_beamformer_param at NUM_CH=4, DATA_W=16, DEPTH=32.
module tb_rx_beamformer_param;
  import rx_bf_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] adc_in;
  logic        cfg_wr;
  logic [1:0]  cfg_ch;
  logic [5:0]  cfg_delay;
  logic [7:0]  cfg_weight;
  logic        cfg_commit;
  logic        cfg_err;
  logic        out_valid;
  logic [15:0] aggregated_waveform;

  int n_tests;
  int n_fail;
  int pcyc;
  int got_cyc[$];
  int got_val[$];
  int exp_cyc[$];
  int exp_val[$];

  rx_beamformer_param #(
    .NUM_CH (4),
    .DATA_W (16),
    .DEPTH  (32)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .adc_in              (adc_in),
    .cfg_wr              (cfg_wr),
    .cfg_ch              (cfg_ch),
    .cfg_delay           (cfg_delay),
    .cfg_weight          (cfg_weight),
    .cfg_commit          (cfg_commit),
    .cfg_err             (cfg_err),
    .out_valid           (out_valid),
    .aggregated_waveform (aggregated_waveform)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every output pulse with the index of the clock edge that produced it.
  initial begin
    pcyc = 0;
    forever begin
      @(posedge clk);
      pcyc++;
      #1;
      if (out_valid === 1'b1) begin
        got_cyc.push_back(pcyc);
        got_val.push_back(int'(aggregated_waveform));
      end
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                      input logic [15:0] d, input bit want, input int expv);
    in_valid = 1'b1;
    adc_in   = {d, c, b, a};
    step();
    in_valid = 1'b0;
    if (want) begin
      exp_cyc.push_back(pcyc + 2);
      exp_val.push_back(expv & 32'hFFFF);
    end
  endtask

  task automatic push_all(input logic [15:0] v, input bit want, input int expv);
    push(v, v, v, v, want, expv);
  endtask

  task automatic cfg_write(input int ch, input int dly);
    cfg_wr    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_delay = 6'(dly);
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  task automatic clear_q();
    got_cyc.delete();
    got_val.delete();
    exp_cyc.delete();
    exp_val.delete();
  endtask

  task automatic compare_run(input string tag);
    int n;
    repeat (4) step();
    check_eq($sformatf("%s_count", tag), got_val.size(), exp_val.size());
    n = (got_val.size() < exp_val.size()) ? got_val.size() : exp_val.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_val%0d", tag, i), got_val[i], exp_val[i]);
      check_eq($sformatf("%s_cyc%0d", tag, i), got_cyc[i], exp_cyc[i]);
    end
    clear_q();
  endtask

  task automatic impulse_run(input string tag);
    for (int i = 0; i < 10; i++)
      push_all((i == 0) ? 16'h4000 : 16'h0000, 1'b1,
               ((i % 2 == 0) && (i <= 6)) ? 32'h1000 : 32'h0);
    compare_run(tag);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    adc_in     = '0;
    cfg_wr     = 1'b0;
    cfg_ch     = '0;
    cfg_delay  = '0;
    cfg_weight = '0;
    cfg_commit = 1'b0;
    repeat (3) step();
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_agg", int'(aggregated_waveform), 0);
    check_eq("rst_cfg_err", int'(cfg_err), 0);
    rst_n = 1'b1;
    step();

    // Zero history with all delays 0; also exercises the 2-edge latency
    for (int i = 0; i < 32; i++) push_all(16'h0000, 1'b1, 0);
    compare_run("prefill");

    // Staggered delays, impulse response
    cfg_write(0, 0);
    cfg_write(1, 2);
    cfg_write(2, 4);
    cfg_write(3, 6);
    commit();
    step();
    impulse_run("impulse");

    // Out-of-range delay is rejected, response unchanged
    cfg_write(1, 2);
    check_eq("err_ok_write", int'(cfg_err), 0);
    cfg_write(1, 32);
    check_eq("err_pulse", int'(cfg_err), 1);
    step();
    check_eq("err_clear", int'(cfg_err), 0);
    commit();
    step();
    impulse_run("bad_delay");

    // Full-scale and rounding corners with zero delays
    for (int ch = 0; ch < 4; ch++) cfg_write(ch, 0);
    commit();
    push_all(16'h7FFF, 1'b1, 32'h7FFF);
    push_all(16'h8000, 1'b1, 32'h8000);
    push(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 1'b1, 32'hFFFF);
    push(16'd100, 16'd200, 16'hFED4, 16'd7, 1'b1, 32'h0001);
    push(16'hFFFB, 16'h0000, 16'h0000, 16'h0000, 1'b1, 32'hFFFE);
    compare_run("sat");

    // Mid-stream commit coinciding with a write, then an idle cycle while pending
    for (int k = 0; k < 30; k++) push_all(16'(16 * k), 1'b1, 16 * k);
    cfg_wr     = 1'b1;
    cfg_ch     = 2'd3;
    cfg_delay  = 6'd20;
    cfg_commit = 1'b1;
    step();
    cfg_wr     = 1'b0;
    cfg_commit = 1'b0;
    step();
    for (int k = 30; k < 40; k++) push_all(16'(16 * k), 1'b1, 16 * k - 80);
    compare_run("commit_mid");

    // Maximum delay after reset: warm-up then ramp across several pointer wraps
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    cfg_write(0, 31);
    commit();
    step();
    for (int n = 0; n < 100; n++) push_all(16'(4 * n), (n >= 31), 4 * n - 31);
    compare_run("ramp");

    // Reset right after an accepted sample drops it
    push_all(16'h0040, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", int'(out_valid), 0);
    check_eq("midrst_agg", int'(aggregated_waveform), 0);
    check_eq("midrst_cfg_err", int'(cfg_err), 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check_eq("midrst_no_output", got_val.size(), 0);
    clear_q();
    push_all(16'd8, 1'b1, 8);
    compare_run("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_beamformer_param.md
RX_BEAMFORMER_PARAM -- requirements
Module: rx_beamformer_param

Interface
REQ-001 Parameter NUM_CH, default 4, meaning receiver channel count; it SHALL be a power of two, 2..16.
REQ-002 Parameter DATA_W, default 16, meaning signed sample width.
REQ-003 Parameter DEPTH, default 32, meaning per-channel circular buffer entries; it SHALL be a power of two; maximum delay is DEPTH-1.
REQ-004 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  sample strobe; adc_in is accepted on every clk edge where it is high.
REQ-007 adc_in  input  NUM_CH x DATA_W  signed per-channel samples.
REQ-008 cfg_wr  input  1  shadow-delay write strobe.
REQ-009 cfg_ch  input  clog2(NUM_CH)  channel to write.
REQ-010 cfg_delay  input  clog2(DEPTH)+1  requested delay in samples.
REQ-011 cfg_weight  input  8  unsigned apodization weight, Q0.8 with 0 = 1.0 (used only under RX_BF_APOD_EN).
REQ-012 cfg_commit  input  1  shadow-to-active copy request.
REQ-013 cfg_err  output  1  one-cycle pulse marking a rejected write.
REQ-014 out_valid  output  1  one-cycle pulse marking a valid aggregated_waveform.
REQ-015 aggregated_waveform  output  DATA_W  signed delay-and-sum result.

Function
REQ-016 The block SHALL keep NUM_CH circular buffers sharing one write pointer that wraps from DEPTH-1 to 0 and advances only on accepted samples.
REQ-017 For the sample accepted at clk edge N, out_valid SHALL pulse at edge N+2 with the result mean over ch of x_ch[n-d_ch], where d_ch is the active delay and d=0 means the current sample.
REQ-018 Sum width SHALL be DATA_W+clog2(NUM_CH); the result SHALL be an arithmetic shift right by clog2(NUM_CH), i.e. floor, never overflowing.
REQ-019 A cfg_wr with cfg_delay > DEPTH-1 SHALL leave the shadow unchanged and pulse cfg_err at the next edge; otherwise it SHALL update shadow[cfg_ch].
REQ-020 cfg_commit SHALL copy all shadow values to active atomically at the next accepted sample; that sample and later ones SHALL use the new delays, and earlier ones SHALL keep the old delays.
REQ-021 When cfg_wr and cfg_commit coincide, the write SHALL land in the shadow first and be included in the commit.
REQ-022 A pending commit SHALL persist across idle cycles until a sample is accepted.
REQ-023 FSM states SHALL be FILL and RUN; fill_cnt SHALL count accepted samples since reset, saturating at DEPTH-1.
REQ-024 In FILL, accepted samples SHALL not produce out_valid while fill_cnt < max active delay.
REQ-025 The FSM SHALL move FILL->RUN when fill_cnt >= max active delay.
REQ-026 The FSM SHALL move RUN->FILL when a commit raises the max delay above fill_cnt.

Reset
REQ-027 On rst_n low the block SHALL set write pointer, fill_cnt, all active and shadow delays, pending commit, out_valid, cfg_err and aggregated_waveform to 0, with FSM=RUN (max delay 0).
REQ-028 Buffer contents SHALL NOT require reset.
REQ-029 Reset mid-pipeline SHALL drop all in-flight results, with no out_valid after release until a new sample is accepted.

Configuration
REQ-030 With RX_BF_APOD_EN defined, each channel SHALL have shadow and active weights, written by cfg_wr and committed with delays; each tap SHALL be multiplied by (weight==0 ? 256 : weight) before summing, and the result shifted by 8+clog2(NUM_CH); latency SHALL stay 2.
REQ-031 With RX_BF_APOD_EN undefined, cfg_weight SHALL be ignored and no multipliers synthesised.

Structure
REQ-032 Package rx_bf_pkg SHALL hold the default NUM_CH/DATA_W/DEPTH constants, the state enum typedef (FILL, RUN), and the sample/delay typedefs.
REQ-033 Sub-module rx_delay_line SHALL implement one channel's circular buffer with registered read, instantiated NUM_CH times.

Verification (NUM_CH=4, DATA_W=16, DEPTH=32)
REQ-034 Delays 0,2,4,6 committed, then an impulse 0x4000 on all channels at sample 0 and zeros after -> outputs 0x1000 at samples 0,2,4,6 and 0 elsewhere, each 2 clk after acceptance.
REQ-035 cfg_delay=32 on ch1 -> cfg_err pulses once; the subsequent response is identical to delays unchanged.
REQ-036 100-sample ramp on all channels with delays 31,0,0,0 -> valid output resumes after fill_cnt=31 and matches the model across at least three pointer wraps.
REQ-037 All channels 0x7FFF -> 0x7FFF; all 0x8000 -> 0x8000; mixed 0x7FFF,0x7FFF,0x8000,0x8000 -> 0xFFFF.
REQ-038 Commit raising ch3 from 0 to 20 mid-stream at fill_cnt=31 (saturated) -> no FILL entry, and the new delay applies exactly from the next accepted sample.
REQ-039 rst_n pulsed low between two accepted samples -> no out_valid for in-flight samples, and all outputs read 0 during reset.
